// File: rtl/automorph_addr_gen.sv
// Streaming Galois-automorphism address generator: i -> i*GEN^r mod M.
// One rotation command is accepted in IDLE. The rotation factor k = GEN^r
// is then built on chip in POW, one multiply by the constant GEN per cycle.
// SWEEP emits LANES source/destination index pairs per beat over a
// valid/ready stream.
// Optional feature macro: AUTOMORPH_SIGN_EN. When it is defined, the
// arithmetic is done mod 2N and out_neg reports the negacyclic sign. When it
// is undefined, the arithmetic is done mod N and out_neg is always 0.
module automorph_addr_gen #(
  parameter int LOG_N  = 16,
  parameter int LANES  = 4,
  parameter int R_BITS = 5,
  parameter int GEN    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [R_BITS-1:0]      cmd_rot,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LOG_N-1:0] out_src,
  output logic [LANES*LOG_N-1:0] out_dst,
  output logic [LANES-1:0]       out_neg,
  output logic                   out_last,
  output logic                   busy
);

`ifdef AUTOMORPH_SIGN_EN
  localparam int K_W = LOG_N + 1;
`else
  localparam int K_W = LOG_N;
`endif
  localparam int LANE_BITS = $clog2(LANES);
  localparam int B_W = (LOG_N > LANE_BITS) ? (LOG_N - LANE_BITS) : 1;
  localparam int NUM_BEATS = 1 << (LOG_N - LANE_BITS);
  localparam logic [B_W-1:0] LAST_BEAT = B_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE, POW, SWEEP} state_t;

  state_t         state;
  state_t         state_next;
  logic [K_W-1:0] k;
  logic [K_W-1:0] k_gen;
  logic [K_W-1:0] k_init;
  logic [K_W-1:0] step;
  logic [K_W-1:0] acc [LANES];
  logic [R_BITS-1:0] rcnt;
  logic [B_W-1:0] beat;
  logic           enter_sweep;
  logic           last_xfer;
  logic           load_beat;

  // Mod-M reductions are plain truncations because M is a power of two.
  // k_init is the factor that is in force once SWEEP is entered. It is 1 for
  // r == 0, and otherwise it is the product that POW forms on its last cycle.
  assign k_gen       = k * K_W'(GEN);
  assign k_init      = (state == IDLE) ? K_W'(1) : k_gen;
  assign enter_sweep = (state != SWEEP) && (state_next == SWEEP);
  assign last_xfer   = out_valid && out_ready && out_last;
  // A beat held under backpressure (out_valid && !out_ready) blocks loading.
  // A held last beat therefore also stops any further load.
  assign load_beat   = (state == SWEEP) && !last_xfer && (!out_valid || out_ready);
  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state. POW is skipped for r == 0 and otherwise lasts exactly r cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = (cmd_rot == '0) ? SWEEP : POW;
      POW:     if (rcnt == R_BITS'(1)) state_next = SWEEP;
      SWEEP:   if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Factor computation, per-lane accumulators and the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      k         <= '0;
      rcnt      <= '0;
      beat      <= '0;
      step      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_src   <= '0;
      out_dst   <= '0;
      out_neg   <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        k    <= K_W'(1);
        rcnt <= cmd_rot;
        beat <= '0;
      end
      if (state == POW) begin
        k    <= k_gen;
        rcnt <= rcnt - R_BITS'(1);
      end
      if (enter_sweep) begin
        step <= k_init << LANE_BITS;
        for (int l = 0; l < LANES; l++) acc[l] <= K_W'(l) * k_init;
      end
      if (last_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else if (load_beat) begin
        out_valid <= 1'b1;
        out_last  <= (beat == LAST_BEAT);
        beat      <= beat + B_W'(1);
        for (int l = 0; l < LANES; l++) begin
          out_src[l*LOG_N +: LOG_N] <= (LOG_N'(beat) << LANE_BITS) | LOG_N'(l);
          out_dst[l*LOG_N +: LOG_N] <= acc[l][LOG_N-1:0];
`ifdef AUTOMORPH_SIGN_EN
          out_neg[l] <= acc[l][K_W-1];
`else
          out_neg[l] <= 1'b0;
`endif
          acc[l] <= acc[l] + step;
        end
      end
    end
  end

endmodule

// File: tb/tb_automorph_addr_gen.sv
// Directed bench for automorph_addr_gen with N = 32 and LANES = 4.
// Vectors are hand-computed. An independent multiply-based model also checks
// every beat of every sweep.
module tb_automorph_addr_gen;

`ifdef AUTOMORPH_SIGN_EN
  localparam bit SIGN = 1'b1;
`else
  localparam bit SIGN = 1'b0;
`endif
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_rot;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_src;
  logic [19:0] out_dst;
  logic [3:0]  out_neg;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [19:0] cap_src [NB];
  logic [19:0] cap_dst [NB];
  logic [3:0]  cap_neg [NB];
  logic        cap_last [NB];

  typedef struct {
    logic [4:0]  rot;
    int          beat;
    logic [19:0] dst;
    logic [3:0]  neg;
  } vec_t;

  vec_t vecs [6];

  automorph_addr_gen #(.LOG_N(5), .LANES(4), .R_BITS(5), .GEN(5)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rot(cmd_rot), .out_valid(out_valid), .out_ready(out_ready),
    .out_src(out_src), .out_dst(out_dst), .out_neg(out_neg),
    .out_last(out_last), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [19:0] pack4(int a0, int a1, int a2, int a3);
    return {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("reset_cmd_ready", cmd_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_out_src", out_src, 0);
    checkOutput("reset_out_dst", out_dst, 0);
    checkOutput("reset_out_neg", out_neg, 0);
  endtask

  // Runs one full rotation sweep, optionally stalling or pulsing a command, and
  // checks every beat against the multiply-based model.
  task automatic applyStimulus(input logic [4:0] rot, input int stall_beat,
                               input int stall_len, input bit pulse_cmd);
    int e, nb, cyc, stalls, kk, m, i, p;
    bit pulsed;
    logic [19:0] hold_src, hold_dst, exp_src, exp_dst;
    logic [3:0]  hold_neg, exp_neg;
    logic        hold_last;
    logic [31:0] seen;
    e = 0; nb = 0; cyc = 0; stalls = 0; pulsed = 1'b0;
    hold_src = '0; hold_dst = '0; hold_neg = '0; hold_last = 1'b0;
    out_ready = 1'b1;
    cmd_rot = rot;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput("busy_after_accept", busy, 1);
    checkOutput("cmd_ready_after_accept", cmd_ready, 0);
    while (!out_valid && e < 100) begin
      @(posedge clk); #1;
      e++;
    end
    checkOutput($sformatf("first_valid_latency_r%0d", rot), e, 32'(rot) + 1);
    while (nb < NB && cyc < 200) begin
      if (nb == stall_beat && stalls < stall_len) begin
        out_ready = 1'b0;
        if (stalls == 0) begin
          hold_src = out_src; hold_dst = out_dst; hold_neg = out_neg; hold_last = out_last;
        end
        @(posedge clk); #1;
        cyc++; stalls++;
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_src", out_src, hold_src);
        checkOutput("stall_dst", out_dst, hold_dst);
        checkOutput("stall_neg", out_neg, hold_neg);
        checkOutput("stall_last", out_last, hold_last);
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          cap_src[nb] = out_src; cap_dst[nb] = out_dst;
          cap_neg[nb] = out_neg; cap_last[nb] = out_last;
          nb++;
        end
        if (pulse_cmd && !pulsed && nb == 4) begin
          pulsed = 1'b1;
          cmd_rot = 5'd3;
          cmd_valid = 1'b1;
          checkOutput("pulse_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc++;
      end
    end
    checkOutput("beat_count", nb, NB);
    checkOutput("sweep_cycles", cyc, NB + stall_len);
    checkOutput("end_out_valid", out_valid, 0);
    checkOutput("end_cmd_ready", cmd_ready, 1);
    checkOutput("end_busy", busy, 0);
    m = SIGN ? 64 : 32;
    kk = 1;
    repeat (rot) kk = (kk * 5) % m;
    seen = '0;
    for (int b = 0; b < NB; b++) begin
      for (int l = 0; l < 4; l++) begin
        i = b * 4 + l;
        p = (i * kk) % m;
        exp_src[l*5 +: 5] = 5'(i);
        exp_dst[l*5 +: 5] = 5'(p % 32);
        exp_neg[l] = SIGN && (p >= 32);
        seen[cap_dst[b][l*5 +: 5]] = 1'b1;
      end
      checkOutput($sformatf("src_r%0d_b%0d", rot, b), cap_src[b], exp_src);
      checkOutput($sformatf("dst_r%0d_b%0d", rot, b), cap_dst[b], exp_dst);
      checkOutput($sformatf("neg_r%0d_b%0d", rot, b), cap_neg[b], exp_neg);
      checkOutput($sformatf("last_r%0d_b%0d", rot, b), cap_last[b], (b == NB - 1) ? 1 : 0);
    end
    checkOutput($sformatf("dst_distinct_r%0d", rot), seen, 32'hFFFF_FFFF);
  endtask

  // Safety net in case the design stops responding.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: table-driven vectors first, then the multi-cycle corner cases.
  initial begin
    bit found;
    int w;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rot = '0; out_ready = 1'b1;

    vecs[0] = '{5'd0, 0, pack4(0, 1, 2, 3),    4'b0000};
    vecs[1] = '{5'd0, 7, pack4(28, 29, 30, 31), 4'b0000};
    vecs[2] = '{5'd1, 0, pack4(0, 5, 10, 15),  4'b0000};
    vecs[3] = '{5'd1, 1, pack4(20, 25, 30, 3), SIGN ? 4'b1000 : 4'b0000};
    vecs[4] = '{5'd2, 0, pack4(0, 25, 18, 11), SIGN ? 4'b0100 : 4'b0000};
    vecs[5] = '{5'd3, 0, pack4(0, 29, 26, 23), SIGN ? 4'b1110 : 4'b0000};

    do_reset();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].rot, -1, 0, 1'b0);
      checkOutput($sformatf("vec%0d_dst", v), cap_dst[vecs[v].beat], vecs[v].dst);
      checkOutput($sformatf("vec%0d_neg", v), cap_neg[vecs[v].beat], vecs[v].neg);
    end

    // Backpressure: three stalled cycles at beat 2.
    applyStimulus(5'd1, 2, 3, 1'b0);

    // Command pulse mid-sweep must be ignored.
    applyStimulus(5'd2, -1, 0, 1'b1);
    checkOutput("pulse_not_queued_busy", busy, 0);

    // Reset at beat 4 aborts the sweep.
    out_ready = 1'b1;
    cmd_rot = 5'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    w = 0;
    while (!found && w < 50) begin
      if (out_valid && out_src[4:0] == 5'd16) found = 1'b1;
      else begin
        @(posedge clk); #1;
        w++;
      end
    end
    checkOutput("rst_seq_reached_beat4", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_mid_out_valid", out_valid, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_cmd_ready", cmd_ready, 1);
    checkOutput("rst_mid_out_dst", out_dst, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput("rst_mid_quiet_valid", out_valid, 0);
    end
    applyStimulus(5'd1, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
